// File: rtl/ymz_pcm_rom_bridge_pkg.sv
// Shared definitions for the YMZ280B to SDRAM PCM bridge: bank geometry,
// bank slot indices and the request FSM state encoding.
package ymz_pcm_rom_bridge_pkg;

  localparam int BANK_AW = 22;

  localparam logic [1:0] BANK_PCM0 = 2'd0;
  localparam logic [1:0] BANK_PCM1 = 2'd1;
  localparam logic [1:0] BANK_PCM2 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    WAITLOW
  } state_t;

endpackage

// File: rtl/ymz_pcm_rom_bridge.sv
// Turns YMZ280B byte reads into per-bank SDRAM CS/ADDR requests and returns
// one byte with a single-cycle valid; a one-entry hit buffer skips repeat reads.
module ymz_pcm_rom_bridge
  import ymz_pcm_rom_bridge_pkg::*;
#(
  parameter int NBANKS  = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic               CLK96,
  input  logic               RESET96,
  input  logic               YMZ_RD,
  input  logic [23:0]        YMZ_ADDR,
  output logic [7:0]         YMZ_DOUT,
  output logic               YMZ_VALID,
  output logic               PCM_CS,
  output logic               PCM1_CS,
  output logic               PCM2_CS,
  output logic [BANK_AW-1:0] PCM_ADDR,
  output logic [BANK_AW-1:0] PCM1_ADDR,
  output logic [BANK_AW-1:0] PCM2_ADDR,
  input  logic               PCM_OK,
  input  logic               PCM1_OK,
  input  logic               PCM2_OK,
  input  logic [7:0]         PCM_DOUT,
  input  logic [7:0]         PCM1_DOUT,
  input  logic [7:0]         PCM2_DOUT
);

  state_t      state, state_nx;
  logic [23:0] a_reg;
  logic [1:0]  bank;
  logic [2:0]  cs;
  logic [9:0]  tmo;
  logic [23:0] hit_addr;
  logic [7:0]  hit_data;
  logic        hit_vld;

  logic [1:0]  rd_bank;
  logic        is_hit;
  logic        in_range;
  logic        ok_sel;
  logic [7:0]  dout_sel;
  logic        ok_take;
  logic        tmo_exp;

  assign rd_bank  = YMZ_ADDR[23:BANK_AW];
  assign is_hit   = hit_vld && (YMZ_ADDR == hit_addr);
  assign in_range = int'(rd_bank) < NBANKS;

  // SDRAM OK is stale in the first REQ cycle (tmo still 0), so it only counts afterwards.
  assign ok_take = ok_sel && (tmo != 10'd0);
  assign tmo_exp = (tmo == 10'(TIMEOUT - 1));

  always_comb begin
    ok_sel   = 1'b0;
    dout_sel = 8'd0;
    case (bank)
      BANK_PCM0: begin ok_sel = PCM_OK;  dout_sel = PCM_DOUT;  end
      BANK_PCM1: begin ok_sel = PCM1_OK; dout_sel = PCM1_DOUT; end
      BANK_PCM2: begin ok_sel = PCM2_OK; dout_sel = PCM2_DOUT; end
      default:   begin ok_sel = 1'b0;    dout_sel = 8'd0;      end
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (YMZ_RD) state_nx = (is_hit || !in_range) ? DONE : REQ;
      REQ: begin
        if (!YMZ_RD)                 state_nx = IDLE;
        else if (ok_take || tmo_exp) state_nx = DONE;
      end
      DONE:    state_nx = WAITLOW;
      WAITLOW: if (!YMZ_RD) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) state <= IDLE;
    else         state <= state_nx;
  end

  // Datapath: OK is checked before the timeout so a last-cycle OK still delivers data.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      YMZ_DOUT  <= 8'd0;
      YMZ_VALID <= 1'b0;
      a_reg     <= 24'd0;
      bank      <= 2'd0;
      cs        <= 3'd0;
      tmo       <= 10'd0;
      hit_addr  <= 24'd0;
      hit_data  <= 8'd0;
      hit_vld   <= 1'b0;
    end else begin
      YMZ_VALID <= (state == DONE);
      case (state)
        IDLE: begin
          if (YMZ_RD) begin
            a_reg <= YMZ_ADDR;
            bank  <= rd_bank;
            tmo   <= 10'd0;
            if (is_hit)         YMZ_DOUT <= hit_data;
            else if (!in_range) YMZ_DOUT <= 8'd0;
            else                cs       <= 3'b001 << rd_bank;
          end
        end
        REQ: begin
          if (!YMZ_RD) begin
            cs <= 3'd0;
          end else if (ok_take) begin
            YMZ_DOUT <= dout_sel;
            hit_addr <= a_reg;
            hit_data <= dout_sel;
            hit_vld  <= 1'b1;
            cs       <= 3'd0;
          end else if (tmo_exp) begin
            YMZ_DOUT <= 8'd0;
            hit_vld  <= 1'b0;
            cs       <= 3'd0;
          end else begin
            tmo <= tmo + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PCM_CS    = cs[0];
  assign PCM1_CS   = cs[1];
  assign PCM2_CS   = cs[2];
  assign PCM_ADDR  = a_reg[BANK_AW-1:0];
  assign PCM1_ADDR = a_reg[BANK_AW-1:0];
  assign PCM2_ADDR = a_reg[BANK_AW-1:0];

endmodule

// File: tb/tb_ymz_pcm_rom_bridge.sv
// Scoreboard bench for ymz_pcm_rom_bridge: a reference model of the hit buffer and
// bank map queues expected bytes; a monitor pops them on every YMZ_VALID.
module tb_ymz_pcm_rom_bridge;

  logic        CLK96 = 1'b0;
  logic        RESET96;
  logic        YMZ_RD;
  logic [23:0] YMZ_ADDR;
  logic [7:0]  YMZ_DOUT;
  logic        YMZ_VALID;
  logic        PCM_CS, PCM1_CS, PCM2_CS;
  logic [21:0] PCM_ADDR, PCM1_ADDR, PCM2_ADDR;
  logic [2:0]  ok_r = 3'b000;
  logic [7:0]  dout_r [3] = '{8'd0, 8'd0, 8'd0};
  logic [2:0]  cs_bus;

  always #5 CLK96 = ~CLK96;

  ymz_pcm_rom_bridge dut (
    .CLK96     (CLK96),
    .RESET96   (RESET96),
    .YMZ_RD    (YMZ_RD),
    .YMZ_ADDR  (YMZ_ADDR),
    .YMZ_DOUT  (YMZ_DOUT),
    .YMZ_VALID (YMZ_VALID),
    .PCM_CS    (PCM_CS),
    .PCM1_CS   (PCM1_CS),
    .PCM2_CS   (PCM2_CS),
    .PCM_ADDR  (PCM_ADDR),
    .PCM1_ADDR (PCM1_ADDR),
    .PCM2_ADDR (PCM2_ADDR),
    .PCM_OK    (ok_r[0]),
    .PCM1_OK   (ok_r[1]),
    .PCM2_OK   (ok_r[2]),
    .PCM_DOUT  (dout_r[0]),
    .PCM1_DOUT (dout_r[1]),
    .PCM2_DOUT (dout_r[2])
  );

  assign cs_bus = {PCM2_CS, PCM1_CS, PCM_CS};

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  cs_mask;
    logic [23:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;

  bit          m_hit_vld  = 1'b0;
  logic [23:0] m_hit_addr = 24'd0;
  logic [7:0]  m_hit_data = 8'd0;

  logic [7:0] resp_data  [3] = '{8'd0, 8'd0, 8'd0};
  int         resp_dly   [3] = '{0, 0, 0};
  bit         resp_never [3] = '{1'b0, 1'b0, 1'b0};
  bit         started    [3] = '{1'b0, 1'b0, 1'b0};
  int         cnt        [3] = '{0, 0, 0};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // SDRAM slot model: idle slots show a stale OK with junk data; a selected slot
  // answers resp_dly cycles after it first sees its CS (or never).
  always @(posedge CLK96) begin
    for (int b = 0; b < 3; b++) begin
      if (cs_bus[b]) begin
        if (!started[b]) begin
          started[b] = 1'b1;
          cnt[b]     = resp_dly[b];
        end
        if (resp_never[b]) begin
          ok_r[b] <= 1'b0;
        end else if (cnt[b] == 0) begin
          ok_r[b]   <= 1'b1;
          dout_r[b] <= resp_data[b];
        end else begin
          ok_r[b] <= 1'b0;
          cnt[b]  = cnt[b] - 1;
        end
      end else begin
        started[b] = 1'b0;
        ok_r[b]   <= 1'b1;
        dout_r[b] <= 8'($urandom);
      end
    end
  end

  // Monitor: accumulates CS activity per transaction and checks on each VALID.
  logic [2:0] cs_seen   = 3'd0;
  int         cs_cycles = 0;
  bit         addr_bad  = 1'b0;
  bit         multi_cs  = 1'b0;
  bit         mon_clear = 1'b0;
  exp_t       mon_e;

  always @(negedge CLK96) begin
    if (mon_clear) begin
      cs_seen = 3'd0; cs_cycles = 0; addr_bad = 1'b0; multi_cs = 1'b0; mon_clear = 1'b0;
    end
    if (cs_bus != 3'd0) begin
      cs_seen = cs_seen | cs_bus;
      cs_cycles++;
      if ($countones(cs_bus) > 1) multi_cs = 1'b1;
      if (sb_q.size() > 0) begin
        if (PCM_ADDR != sb_q[0].addr[21:0] || PCM1_ADDR != sb_q[0].addr[21:0] ||
            PCM2_ADDR != sb_q[0].addr[21:0])
          addr_bad = 1'b1;
      end
    end
    if (YMZ_VALID) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_valid: got VALID with DOUT 0x%0h, expected no VALID (t=%0t)",
                 YMZ_DOUT, $time);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("dout", 32'(YMZ_DOUT), 32'(mon_e.data));
        checkOutput("cs_banks", 32'(cs_seen), 32'(mon_e.cs_mask));
        checkOutput("cs_onehot", 32'(multi_cs), 32'd0);
        if (mon_e.cs_mask != 3'd0) begin
          checkOutput("pcm_addr", 32'(addr_bad), 32'd0);
          checkOutput("cs_min_2cycles", 32'(cs_cycles >= 2), 32'd1);
        end
      end
      cs_seen = 3'd0; cs_cycles = 0; addr_bad = 1'b0; multi_cs = 1'b0;
    end
  end

  // One full read: reference model decides the answer, then RD is driven until VALID.
  task automatic applyStimulus(input logic [23:0] addr, input logic [7:0] data,
                               input int dly, input bit never, input int hold);
    int   b;
    int   lat;
    int   exp_lat;
    bit   got;
    exp_t e;
    b      = int'(addr[23:22]);
    e.addr = addr;
    if (m_hit_vld && addr == m_hit_addr) begin
      e.data = m_hit_data; e.cs_mask = 3'd0; exp_lat = 2;
    end else if (b >= 3) begin
      e.data = 8'd0; e.cs_mask = 3'd0; exp_lat = 2;
    end else begin
      resp_data[b]  = data;
      resp_dly[b]   = dly;
      resp_never[b] = never;
      e.cs_mask     = 3'(1 << b);
      if (never) begin
        e.data = 8'd0; m_hit_vld = 1'b0; exp_lat = -1;
      end else begin
        e.data = data; m_hit_vld = 1'b1; m_hit_addr = addr; m_hit_data = data;
        exp_lat = 3 + (dly + 1);
      end
    end
    sb_q.push_back(e);
    @(posedge CLK96); #1;
    YMZ_ADDR = addr;
    YMZ_RD   = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 1200) begin
      @(posedge CLK96);
      lat++;
      @(negedge CLK96);
      if (YMZ_VALID) got = 1'b1;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("[TB] FAIL valid_wait: got no VALID in %0d cycles, expected VALID for addr 0x%06h",
               lat, addr);
    end else if (exp_lat > 0) begin
      checkOutput("latency", 32'(lat), 32'(exp_lat));
    end
    repeat (hold) @(posedge CLK96);
    @(posedge CLK96); #1;
    YMZ_RD   = 1'b0;
    YMZ_ADDR = 24'($urandom);
  endtask

  task automatic waitForCs(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK96);
      if (cs_bus != 3'd0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("[TB] FAIL cs_rise: got no CS in 10 cycles, expected a bank request");
    end
  endtask

  task automatic abortRequest(input logic [23:0] addr);
    bit seen;
    bit saw_valid;
    resp_never[int'(addr[23:22])] = 1'b1;
    @(posedge CLK96); #1;
    YMZ_ADDR = addr;
    YMZ_RD   = 1'b1;
    waitForCs(seen);
    @(posedge CLK96); #1;
    YMZ_RD = 1'b0;
    @(posedge CLK96);
    @(negedge CLK96);
    checkOutput("abort_cs_low", 32'(cs_bus), 32'd0);
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge CLK96);
      if (YMZ_VALID) saw_valid = 1'b1;
    end
    checkOutput("abort_no_valid", 32'(saw_valid), 32'd0);
    mon_clear = 1'b1;
  endtask

  task automatic resetDuringReq(input logic [23:0] addr);
    bit seen;
    resp_never[int'(addr[23:22])] = 1'b1;
    @(posedge CLK96); #1;
    YMZ_ADDR = addr;
    YMZ_RD   = 1'b1;
    waitForCs(seen);
    @(posedge CLK96); #1;
    RESET96 = 1'b1;
    @(posedge CLK96);
    @(negedge CLK96);
    checkOutput("reset_cs_low", 32'(cs_bus), 32'd0);
    checkOutput("reset_valid_low", 32'(YMZ_VALID), 32'd0);
    checkOutput("reset_dout", 32'(YMZ_DOUT), 32'd0);
    @(posedge CLK96); #1;
    RESET96   = 1'b0;
    YMZ_RD    = 1'b0;
    m_hit_vld = 1'b0;
    mon_clear = 1'b1;
  endtask

  logic [23:0] pool [6];

  initial begin
    RESET96  = 1'b1;
    YMZ_RD   = 1'b0;
    YMZ_ADDR = 24'd0;
    repeat (3) @(posedge CLK96);
    @(negedge CLK96);
    checkOutput("rst_valid", 32'(YMZ_VALID), 32'd0);
    checkOutput("rst_dout", 32'(YMZ_DOUT), 32'd0);
    checkOutput("rst_cs", 32'(cs_bus), 32'd0);
    checkOutput("rst_addr", 32'(PCM_ADDR), 32'd0);
    @(posedge CLK96); #1;
    RESET96 = 1'b0;

    applyStimulus(24'h012345, 8'hA5, 3, 1'b0, 0);
    applyStimulus(24'h012345, 8'h77, 0, 1'b0, 0);
    applyStimulus(24'h512345, 8'h3C, 0, 1'b0, 0);
    applyStimulus(24'hC00010, 8'h55, 0, 1'b0, 0);
    applyStimulus(24'h800004, 8'h11, 2, 1'b0, 0);
    applyStimulus(24'h800000, 8'h66, 0, 1'b1, 0);
    applyStimulus(24'h800004, 8'h22, 1, 1'b0, 0);
    applyStimulus(24'h000100, 8'hE7, 2, 1'b0, 20);
    abortRequest(24'h000200);
    applyStimulus(24'h000100, 8'h00, 0, 1'b0, 0);
    resetDuringReq(24'h400300);
    applyStimulus(24'h400300, 8'h5E, 1, 1'b0, 0);

    for (int i = 0; i < 5; i++) pool[i] = 24'($urandom);
    pool[5] = {2'b11, 22'($urandom)};
    for (int i = 0; i < 40; i++) begin
      applyStimulus(pool[$urandom_range(0, 5)], 8'($urandom), int'($urandom_range(0, 5)),
                    1'b0, int'($urandom_range(0, 3)));
    end

    repeat (5) @(posedge CLK96);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
